// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths and arbiter state encoding for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    typedef enum logic {
        LD_PRI    = 1'b0,
        ALU_FORCE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb_req_fifo.sv
// Synchronous request FIFO with occupancy count; 1-cycle push-to-visible latency, no bypass.
// Pushes are dropped when full and pops when empty; the caller gates on full/empty.
module wb_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Single register-file write port shared by ALU and load returns; registered write 1 cycle after grant.
// Loads win unless starving a queued ALU result; alu_ready tracks queue space, ld_ready is the load grant.
module regfile_wb_scheduler #(
    parameter int AW          = regfile_wb_scheduler_pkg::AW,
    parameter int DW          = regfile_wb_scheduler_pkg::DW,
    parameter int ALU_Q_DEPTH = 2,
    parameter int MAX_WAIT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AW-1:0]     alu_rd,
    input  logic [DW-1:0]     alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [AW-1:0]     ld_rd,
    input  logic [DW-1:0]     ld_data,
    input  logic              ld_issue,
    input  logic [AW-1:0]     ld_issue_rd,
    input  logic [AW-1:0]     rs1,
    input  logic [AW-1:0]     rs2,
    output logic              stall,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic [2**AW-1:0]  pending
);

    import regfile_wb_scheduler_pkg::*;

    localparam int CW  = $clog2(ALU_Q_DEPTH) + 1;
    localparam int WCW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0]    q_count;
    logic             q_full;
    logic             q_empty;
    logic [AW+DW-1:0] q_head;
    logic [AW-1:0]    q_rd;
    logic [DW-1:0]    q_data;

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [WCW-1:0]   wait_cnt;
    logic [WCW-1:0]   wait_nxt;
    logic             grant_ld;
    logic             grant_alu;
    logic [AW-1:0]    win_rd;
    logic [DW-1:0]    win_data;
    logic             win_we;
    logic [2**AW-1:0] pending_nxt;

    assign alu_ready = (q_count < CW'(ALU_Q_DEPTH));

    wb_req_fifo #(
        .DEPTH (ALU_Q_DEPTH),
        .WIDTH (AW + DW)
    ) u_alu_q (
        .clk       (clk),
        .rst       (rst),
        .push      (alu_valid & ~q_full),
        .push_data ({alu_rd, alu_data}),
        .pop       (grant_alu),
        .pop_data  (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign {q_rd, q_data} = q_head;

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        grant_ld  = 1'b0;
        grant_alu = 1'b0;
        case (state)
            LD_PRI: begin
                if (ld_valid) begin
                    grant_ld = 1'b1;
                    wait_nxt = q_empty ? '0 : wait_cnt + 1'b1;
                    // The ALU head has now lost MAX_WAIT grants in a row.
                    if (!q_empty && wait_nxt >= WCW'(MAX_WAIT)) state_nxt = ALU_FORCE;
                end else if (!q_empty) begin
                    grant_alu = 1'b1;
                    wait_nxt  = '0;
                end
            end
            ALU_FORCE: begin
                grant_alu = ~q_empty;
                wait_nxt  = '0;
                state_nxt = LD_PRI;
            end
            default: state_nxt = LD_PRI;
        endcase
    end

    assign ld_ready = grant_ld;
    assign win_rd   = grant_ld ? ld_rd : q_rd;
    assign win_data = grant_ld ? ld_data : q_data;
    assign win_we   = (grant_ld | grant_alu) && (win_rd != '0);

    always_comb begin
        pending_nxt = pending;
        if (grant_ld) pending_nxt[ld_rd] = 1'b0;
        // Applied second so a newly issued load to the same rd stays pending.
        if (ld_issue && ld_issue_rd != '0) pending_nxt[ld_issue_rd] = 1'b1;
    end

    assign stall = ((rs1 != '0) && pending[rs1]) || ((rs2 != '0) && pending[rs2]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= LD_PRI;
            wait_cnt <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            pending  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            rf_we    <= win_we;
            pending  <= pending_nxt;
            if (win_we) begin
                rf_waddr <= win_rd;
                rf_wdata <= win_data;
            end
        end
    end

endmodule
